seg7_display_ctrl: RTL
======================

Name: seg7_display_ctrl

Overview:
- Parametrised multi-digit seven-segment display controller, next generation of the single-digit binary-to-segment path on the DE-series board top level.
- Registers a binary value through a load/busy handshake and shows it on DIGITS displays in hex or in decimal.
- Decimal mode uses a sequential double-dabble BCD converter.
- Adds leading-zero blanking, overflow indication and per-digit blinking.
- Instantiated directly in the board top level, driving SEM.

Parameters:
DIGITS, 4, number of seven-segment digits driven (1..8)
DATA_W, 16, width of the binary input value (1..32)
BLINK_DIV, 5000000, clock cycles per blink half-period (at least 2)

Ports:
CLOCK_50  input  1  system clock; all logic on its rising edge
RESET_N  input  1  asynchronous active-low reset
value_in  input  DATA_W  binary value to display
dec_mode  input  1  1 = decimal, 0 = hex; sampled with load
lz_en  input  1  leading-zero blanking enable; applied continuously
load  input  1  request to capture value_in
busy  output  1  conversion in progress; load ignored while high
blink_mask  input  DIGITS  per-digit blink enable
dp_mask  input  DIGITS  per-digit decimal point (only with SEG7_DP_EN)
SEM  output  DIGITS x 8  SEM[d] drives digit d (0 = rightmost); active-low segments, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g, bit7=dp

Behaviour:
- Clock and reset: one clock, CLOCK_50; reset is asynchronous and active-low on RESET_N.
- Reset values: SEM all 8'hFF (all off), busy=0, digit registers 0, blink counter 0, blink phase 0, FSM in IDLE.
- FSM states are IDLE and CONV.
- IDLE, load=1, dec_mode=0:
  - Nibble d of value_in goes to digit d. value_in is zero-extended if DATA_W < 4*DIGITS.
  - Digit registers update at the next edge (latency 1). busy stays 0.
- IDLE, load=1, dec_mode=1:
  - Capture value_in into a shift register and clear the BCD accumulator (4*DIGITS+4 bits, one spare digit for overflow detection).
  - Go to CONV. busy=1 from the next edge.
- CONV, one double-dabble step per cycle: add 3 to every BCD nibble >= 5, then shift left one bit from the binary register.
  - Runs for exactly DATA_W cycles.
  - On the final step, write the digit registers and return to IDLE. busy falls on the same edge.
  - Total latency from the load edge is DATA_W+1 edges.
- load while busy=1 is ignored; no queueing. load held high in IDLE restarts the operation each time it is accepted.
- Overflow:
  - Hex: any value_in bit at index >= 4*DIGITS is nonzero.
  - Decimal: spare BCD digit is nonzero.
  - Effect: the overflow flag is set and every digit shows 8'hFE ("-"). Cleared by the next completed load without overflow.
- Hex glyphs 0-F follow the standard patterns (b and d in lower case).
- Leading-zero blanking: with lz_en=1, zero digits above the most significant nonzero digit show 8'hFF. Digit 0 is never blanked. Not applied during overflow.
- Blink:
  - The free-running counter wraps at BLINK_DIV-1 and toggles the phase.
  - During phase=1, digits with blink_mask[d]=1 show 8'hFF, overriding the other rules.
  - blink_mask is not registered.
- SEM is driven from registered digit values and the registered overflow flag, combined combinationally with lz_en, blink_mask and phase.
- Mid-conversion reset aborts the conversion; all outputs return to reset values.

Optional Feature:
- Macro SEG7_DP_EN.
- Defined: dp_mask exists; SEM[d][7] = ~dp_mask[d], blanked together with its digit by blink only.
- Undefined: the dp_mask port is absent; SEM[d][7] is fixed at 1 (off).

Test Plan:
- Reset: assert RESET_N=0 mid-CONV -> busy=0 and all SEM = 8'hFF immediately. After release, the first load behaves normally.
- Hex with blanking: DIGITS=4, DATA_W=16, value_in=16'h00A5, dec_mode=0, lz_en=1, load pulse -> one edge later SEM[3]=FF, SEM[2]=FF, SEM[1]=88, SEM[0]=A4, busy never high. With lz_en=0 -> SEM[3]=SEM[2]=81.
- Decimal: value_in=1234, dec_mode=1 -> busy high for 16 cycles. At edge 17, SEM[3..0] = CF, 92, 86, CC; busy=0.
- Decimal overflow: value_in=12345, dec_mode=1 -> after 17 edges all SEM = FE. Then load 0 in hex -> SEM[0]=81, others FF with lz_en=1.
- Load during busy: second load of 9 issued 5 cycles into a conversion of 42 -> ignored. Display shows "42" (SEM[1]=CC, SEM[0]=92).
- Blink: BLINK_DIV=4, blink_mask=4'b0001, value 0x0005 -> SEM[0] alternates A4/FF every 4 cycles; other digits unchanged. With SEG7_DP_EN and dp_mask=4'b0010, SEM[1][7]=0.

Source files
------------

// File: rtl/seg7_display_ctrl.sv
`timescale 1ns/1ps
// seg7_display_ctrl: multi-digit seven-segment display controller.
// A binary value is captured through a load/busy handshake and shown either
// in hex (direct nibble mapping) or in decimal (sequential double-dabble).
// Output features: leading-zero blanking, overflow dashes, per-digit blink.
// Optional feature macro: SEG7_DP_EN adds the dp_mask port and drives the
// decimal points; without it every decimal point is held off.
module seg7_display_ctrl #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BLINK_DIV = 5000000
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_N,
    input  logic [DATA_W-1:0]      value_in,
    input  logic                   dec_mode,
    input  logic                   lz_en,
    input  logic                   load,
    output logic                   busy,
    input  logic [DIGITS-1:0]      blink_mask,
`ifdef SEG7_DP_EN
    input  logic [DIGITS-1:0]      dp_mask,
`endif
    output logic [DIGITS-1:0][7:0] SEM
);

    localparam int unsigned HEX_W  = 4 * DIGITS;
    localparam int unsigned BCD_W  = 4 * DIGITS + 4;   // one spare digit for overflow
    localparam int unsigned EXT_W  = (DATA_W > HEX_W) ? DATA_W : HEX_W;
    localparam int unsigned STEP_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned CNT_W  = $clog2(BLINK_DIV);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                 state;
    logic [DIGITS-1:0][3:0] digit_q;
    logic                   ovf_q;
    logic                   shown_q;     // a load has completed since reset
    logic [DATA_W-1:0]      bin_q;
    logic [BCD_W-1:0]       bcd_q;
    logic                   lost_q;      // a BCD bit fell off the top of the spare digit
    logic [STEP_W-1:0]      step_q;
    logic [CNT_W-1:0]       blink_cnt;
    logic                   blink_phase;

    logic [EXT_W-1:0]       value_ext;
    logic                   hex_ovf;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_next;
    logic                   upper_zero;
    logic [6:0]             seg7;
    logic                   dp;

    // Active-low a..g glyphs, bit6=a ... bit0=g.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h01;
            4'h1: hex_glyph = 7'h4F;
            4'h2: hex_glyph = 7'h12;
            4'h3: hex_glyph = 7'h06;
            4'h4: hex_glyph = 7'h4C;
            4'h5: hex_glyph = 7'h24;
            4'h6: hex_glyph = 7'h20;
            4'h7: hex_glyph = 7'h0F;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h04;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h60;
            4'hC: hex_glyph = 7'h31;
            4'hD: hex_glyph = 7'h42;
            4'hE: hex_glyph = 7'h30;
            default: hex_glyph = 7'h38;
        endcase
    endfunction

    // Zero-extend the input so the hex path works for any DATA_W vs DIGITS.
    assign value_ext = EXT_W'(value_in);
    assign hex_ovf   = |(value_ext >> HEX_W);

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can infer a latch.
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS) + 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
    end

    // Load/convert FSM with registered busy, digit registers and overflow flag.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
            state   <= IDLE;
            busy    <= 1'b0;
            digit_q <= '0;
            ovf_q   <= 1'b0;
            shown_q <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
            lost_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        if (dec_mode) begin
                            bin_q  <= value_in;
                            bcd_q  <= '0;
                            lost_q <= 1'b0;
                            step_q <= '0;
                            busy   <= 1'b1;
                            state  <= CONV;
                        end else begin
                            digit_q <= value_ext[HEX_W-1:0];
                            ovf_q   <= hex_ovf;
                            shown_q <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    bin_q  <= bin_q << 1;
                    bcd_q  <= bcd_next;
                    lost_q <= lost_q | bcd_adj[BCD_W-1];
                    step_q <= step_q + 1'b1;
                    if (step_q == STEP_W'(DATA_W - 1)) begin
                        digit_q <= bcd_next[HEX_W-1:0];
                        ovf_q   <= (|bcd_next[BCD_W-1:HEX_W]) | lost_q | bcd_adj[BCD_W-1];
                        shown_q <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running blink timebase: phase toggles every BLINK_DIV cycles.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Segment mapping: blink > overflow dash > leading-zero blank > glyph; dark until the first load.
    always_comb begin
        SEM        = '1;
        upper_zero = 1'b1;
        seg7       = '1;
        dp         = 1'b1;
        for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
            upper_zero = upper_zero & (digit_q[d] == 4'd0);
            if (ovf_q)
                seg7 = 7'h7E;
            else if (lz_en && upper_zero && d != 0)
                seg7 = 7'h7F;
            else
                seg7 = hex_glyph(digit_q[d]);
`ifdef SEG7_DP_EN
            dp = ~dp_mask[d];
`else
            dp = 1'b1;
`endif
            if (!shown_q || (blink_phase && blink_mask[d])) begin
                seg7 = 7'h7F;
                dp   = 1'b1;
            end
            SEM[d] = {dp, seg7};
        end
    end

endmodule
